rowmat_scheduler: RTL and testbench
===================================

Name: rowmat_scheduler

Overview:
Sequences one PU_RowMatrix-style processing unit over a multi-row OP1 matrix to compute C = A x W one result row at a time.
- Buffers each incoming A row.
- Kicks the PU and streams the row's elements into it.
- Captures the packed result row and presents it on a valid/ready output.
- Clears the PU accumulators between rows.
- Sits between the host/DMA stream and the PU instance, as the top-level sequencer of the matrix-multiplier datapath.

Parameters:
- OP1_COL, 4, elements per A row (= weight rows); PU_ACC_NUM is driven to OP1_COL-1.
- OP1_WIDTH, 8, signed A element width.
- WEIGHT_COL, 8, PU output lanes.
- DSPOUT_WIDTH, 8, width per output lane.
- MAX_ROWS, 16, maximum A rows per job.
- TIMEOUT_CYCLES, 64, PU_DONE watchdog limit (optional feature only).

Ports:
- CLK  in  1  clock.
- RSTN  in  1  reset, asynchronous, active-low.
- JOB_START  in  1  one-cycle pulse; sampled only in IDLE.
- JOB_ROWS  in  $clog2(MAX_ROWS+1)  row count; sampled with JOB_START; 0 is legal.
- JOB_KEEP_ADDR  in  1  sampled with JOB_START; drives PU_PREVENT_ADR_CLR for the whole job.
- A_VALID  in  1  A element valid.
- A_DATA  in  OP1_WIDTH  A element, row-major order.
- A_READY  out  1  element accepted when A_VALID & A_READY.
- PU_START  out  1  one-cycle start to the PU.
- PU_OP1  out  OP1_WIDTH  element stream to the PU.
- PU_ACC_NUM  out  $clog2(OP1_COL)  constant OP1_COL-1.
- PU_RSTN  out  1  PU soft reset, active-low.
- PU_PREVENT_ADR_CLR  out  1  forwarded job flag.
- PU_DONE  in  1  PU completion level.
- PU_OUT  in  DSPOUT_WIDTH*WEIGHT_COL  PU result row.
- RES_VALID  out  1  result row valid.
- RES_DATA  out  DSPOUT_WIDTH*WEIGHT_COL  captured result row.
- RES_READY  in  1  downstream ready.
- BUSY  out  1  high in any state other than IDLE.
- JOB_DONE  out  1  one-cycle pulse after the last row is accepted, or after a 0-row job.
- ERR  out  1  sticky watchdog flag (optional feature only).

Behaviour:
- Reset (RSTN low, asynchronous):
  - State IDLE; all counters 0; RES_DATA 0.
  - Outputs low: RES_VALID, A_READY, PU_START, BUSY, JOB_DONE, ERR. PU_OP1 = 0.
  - PU_RSTN = 0 while RSTN = 0.
  - Reset mid-job aborts the job; no partial result is emitted.
- State IDLE:
  - On JOB_START, latch JOB_ROWS and JOB_KEEP_ADDR.
  - JOB_ROWS = 0: pulse JOB_DONE next cycle and stay in IDLE.
  - Otherwise go to LOAD.
- State LOAD:
  - A_READY = 1. Elements are written into the row buffer (sub-module) at index col_cnt.
  - After OP1_COL accepts, go to KICK.
- State KICK: PU_START = 1 for exactly one cycle; go to FEED with feed_cnt = 0.
- State FEED:
  - PU_OP1 = buffer[feed_cnt], feed_cnt increments each cycle.
  - Element 0 appears on PU_OP1 in the cycle after PU_START.
  - After OP1_COL cycles, PU_OP1 returns to 0 and the block goes to WAIT.
- State WAIT:
  - On the first cycle PU_DONE = 1: RES_DATA <= PU_OUT, RES_VALID <= 1, go to HOLD.
  - Capture latency is 1 cycle from PU_DONE.
- State HOLD:
  - RES_VALID and RES_DATA are held stable until RES_READY.
  - On the handshake, RES_VALID drops, row_cnt increments, go to CLR.
- State CLR:
  - PU_RSTN = 0 for exactly one cycle. This clears the DSP accumulators and the PU FSM.
  - The PU BRAM address clears only if PU_PREVENT_ADR_CLR = 0.
  - Then row_cnt == JOB_ROWS: go to IDLE and pulse JOB_DONE. Otherwise go to LOAD.
- Ordering rule: A_READY stays low outside LOAD. Input for the next row is never accepted before the previous result is handshaked.
- Counter widths:
  - col_cnt and feed_cnt: $clog2(OP1_COL+1).
  - row_cnt: width of JOB_ROWS.
  - No wrap-around occurs because JOB_ROWS <= MAX_ROWS.
- JOB_ROWS > MAX_ROWS: clamp to MAX_ROWS.
- JOB_START outside IDLE is ignored.
- PU_DONE asserted in any state other than WAIT is ignored.
- RES_READY held high in HOLD: the handshake completes in the same cycle RES_VALID is seen.

Optional Feature:
- Macro: RMS_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES without PU_DONE: set ERR (sticky until RSTN), pulse PU_RSTN for one cycle, abort the job to IDLE, pulse JOB_DONE. No RES_VALID is produced.
- Undefined:
  - WAIT has no time limit.
  - ERR is tied to 0 and the counter is not instantiated.

Decomposition:
- Shared package rowmat_pkg holds:
  - the state enum type (IDLE, LOAD, KICK, FEED, WAIT, HOLD, CLR);
  - default widths OP1_COL, OP1_WIDTH, WEIGHT_COL, DSPOUT_WIDTH;
  - the localparam RES_W = DSPOUT_WIDTH*WEIGHT_COL.
- One sub-module, rowmat_row_buffer:
  - OP1_COL x OP1_WIDTH register file;
  - write port with index;
  - combinational read by index;
  - no reset on contents.

Test Plan:
- JOB_ROWS=1, A row {1,2,3,4}, PU model returns W=identity-like lanes: PU_START 1 cycle after the 4th accept; PU_OP1 shows 1,2,3,4 on consecutive cycles; RES_DATA = model output; JOB_DONE 1 cycle after CLR.
- JOB_ROWS=3 with RES_READY low for 5 cycles on row 2: RES_DATA stable for all 5 cycles; A_READY stays 0 until after the CLR pulse; exactly 3 results; exactly one JOB_DONE.
- JOB_ROWS=0: JOB_DONE pulses the next cycle; BUSY never rises; PU_START never pulses.
- Gaps in A_VALID (element, 2 idle cycles, element, …): 4 accepts only; PU_START waits for the 4th accept.
- RSTN dropped during FEED: outputs take their reset values immediately (asynchronous); no RES_VALID; a new JOB_START after reset runs cleanly.
- With RMS_WATCHDOG_EN, TIMEOUT_CYCLES=64, PU_DONE never asserted: ERR rises at cycle 64 of WAIT; PU_RSTN pulses once; JOB_DONE pulses; BUSY falls.

Source files
------------

// File: rtl/rowmat_pkg.sv
// rowmat_pkg: shared state encoding and default widths for the row-matrix
// scheduler and its row buffer.
`timescale 1ns/1ps
package rowmat_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KICK,
    FEED,
    WAIT,
    HOLD,
    CLR
  } state_t;

  localparam int OP1_COL      = 4;
  localparam int OP1_WIDTH    = 8;
  localparam int WEIGHT_COL   = 8;
  localparam int DSPOUT_WIDTH = 8;
  localparam int RES_W        = DSPOUT_WIDTH * WEIGHT_COL;

endpackage

// File: rtl/rowmat_row_buffer.sv
// rowmat_row_buffer: one A row of DEPTH elements. Indexed write port,
// combinational indexed read. Contents are not reset; every entry is written
// during LOAD before it is read during FEED.
`timescale 1ns/1ps
module rowmat_row_buffer
  import rowmat_pkg::*;
#(
  parameter int DEPTH = OP1_COL,
  parameter int WIDTH = OP1_WIDTH
)(
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // write the accepted element at its column slot
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rowmat_scheduler.sv
// rowmat_scheduler: sequences one PU_RowMatrix unit over a job of A rows.
// Per row: buffer OP1_COL elements, kick the PU, stream the row into it,
// capture the packed result, hand it off on valid/ready, soft-reset the PU.
// Optional PU_DONE watchdog: define RMS_WATCHDOG_EN.
`timescale 1ns/1ps
module rowmat_scheduler
  import rowmat_pkg::*;
#(
  parameter int OP1_COL      = rowmat_pkg::OP1_COL,
  parameter int OP1_WIDTH    = rowmat_pkg::OP1_WIDTH,
  parameter int WEIGHT_COL   = rowmat_pkg::WEIGHT_COL,
  parameter int DSPOUT_WIDTH = rowmat_pkg::DSPOUT_WIDTH,
  parameter int MAX_ROWS     = 16
`ifdef RMS_WATCHDOG_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
)(
  input  logic                               CLK,
  input  logic                               RSTN,
  input  logic                               JOB_START,
  input  logic [$clog2(MAX_ROWS+1)-1:0]      JOB_ROWS,
  input  logic                               JOB_KEEP_ADDR,
  input  logic                               A_VALID,
  input  logic [OP1_WIDTH-1:0]               A_DATA,
  output logic                               A_READY,
  output logic                               PU_START,
  output logic [OP1_WIDTH-1:0]               PU_OP1,
  output logic [$clog2(OP1_COL)-1:0]         PU_ACC_NUM,
  output logic                               PU_RSTN,
  output logic                               PU_PREVENT_ADR_CLR,
  input  logic                               PU_DONE,
  input  logic [DSPOUT_WIDTH*WEIGHT_COL-1:0] PU_OUT,
  output logic                               RES_VALID,
  output logic [DSPOUT_WIDTH*WEIGHT_COL-1:0] RES_DATA,
  input  logic                               RES_READY,
  output logic                               BUSY,
  output logic                               JOB_DONE,
  output logic                               ERR
);

  localparam int RW       = $clog2(MAX_ROWS+1);
  localparam int CW       = $clog2(OP1_COL+1);
  localparam int IW       = $clog2(OP1_COL);
  localparam int RES_BITS = DSPOUT_WIDTH * WEIGHT_COL;

  state_t                state, state_nxt;
  logic [RW-1:0]         job_rows, row_cnt, rows_clamped;
  logic                  keep_adr;
  logic [CW-1:0]         col_cnt, feed_cnt;
  logic [RES_BITS-1:0]   res_data;
  logic                  job_done;
  logic [OP1_WIDTH-1:0]  buf_rd;
  logic                  accept, last_col, last_feed, last_row;
  logic                  timeout, wd_rst;

  assign rows_clamped = (JOB_ROWS > RW'(MAX_ROWS)) ? RW'(MAX_ROWS) : JOB_ROWS;
  assign accept       = A_VALID && (state == LOAD);
  assign last_col     = (col_cnt == CW'(OP1_COL-1));
  assign last_feed    = (feed_cnt == CW'(OP1_COL-1));
  assign last_row     = (row_cnt == job_rows);

  rowmat_row_buffer #(
    .DEPTH (OP1_COL),
    .WIDTH (OP1_WIDTH)
  ) u_row_buffer (
    .clk   (CLK),
    .we    (accept),
    .waddr (col_cnt[IW-1:0]),
    .wdata (A_DATA),
    .raddr (feed_cnt[IW-1:0]),
    .rdata (buf_rd)
  );

  // state register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    A_READY   = 1'b0;
    PU_START  = 1'b0;
    RES_VALID = 1'b0;
    BUSY      = (state != IDLE);
    case (state)
      IDLE: if (JOB_START && (rows_clamped != '0)) state_nxt = LOAD;
      LOAD: begin
        A_READY = 1'b1;
        if (accept && last_col) state_nxt = KICK;
      end
      KICK: begin
        PU_START  = 1'b1;
        state_nxt = FEED;
      end
      FEED: if (last_feed) state_nxt = WAIT;
      WAIT: begin
        if (PU_DONE)      state_nxt = HOLD;
        else if (timeout) state_nxt = IDLE;
      end
      HOLD: begin
        RES_VALID = 1'b1;
        if (RES_READY) state_nxt = CLR;
      end
      CLR:     state_nxt = last_row ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // job latch, row/column/feed counters, result capture, done pulse
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      job_rows <= '0;
      keep_adr <= 1'b0;
      row_cnt  <= '0;
      col_cnt  <= '0;
      feed_cnt <= '0;
      res_data <= '0;
      job_done <= 1'b0;
    end else begin
      job_done <= 1'b0;
      case (state)
        IDLE: if (JOB_START) begin
          job_rows <= rows_clamped;
          keep_adr <= JOB_KEEP_ADDR;
          row_cnt  <= '0;
          col_cnt  <= '0;
          job_done <= (rows_clamped == '0);
        end
        LOAD: if (accept) col_cnt <= last_col ? '0 : col_cnt + 1'b1;
        KICK: feed_cnt <= '0;
        FEED: feed_cnt <= feed_cnt + 1'b1;
        WAIT: begin
          if (PU_DONE)      res_data <= PU_OUT;
          else if (timeout) job_done <= 1'b1;
        end
        HOLD: if (RES_READY) row_cnt <= row_cnt + 1'b1;
        CLR:  if (last_row) job_done <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef RMS_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] wd_cnt;
  logic          err;

  assign timeout = (state == WAIT) && !PU_DONE && (wd_cnt == TW'(TIMEOUT_CYCLES-1));

  // WAIT-cycle counter, sticky error and one-cycle PU reset on timeout
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wd_cnt <= '0;
      err    <= 1'b0;
      wd_rst <= 1'b0;
    end else begin
      wd_rst <= timeout;
      if (timeout) err <= 1'b1;
      wd_cnt <= (state == WAIT) ? wd_cnt + 1'b1 : '0;
    end
  end

  assign ERR = err;
`else
  assign timeout = 1'b0;
  assign wd_rst  = 1'b0;
  assign ERR     = 1'b0;
`endif

  // PU is held in reset with the block, and pulsed between rows / on abort
  assign PU_RSTN            = RSTN && (state != CLR) && !wd_rst;
  assign PU_OP1             = (state == FEED) ? buf_rd : '0;
  assign PU_ACC_NUM         = IW'(OP1_COL-1);
  assign PU_PREVENT_ADR_CLR = keep_adr;
  assign RES_DATA           = res_data;
  assign JOB_DONE           = job_done;

endmodule

// File: tb/tb_rowmat_scheduler.sv
// tb_rowmat_scheduler: random A rows through the scheduler with a behavioural
// PU (C row = A row x W, 8-bit lanes). Expected rows are queued at stimulus
// time and popped by a monitor on each result handshake.
`timescale 1ns/1ps
module tb_rowmat_scheduler;
  import rowmat_pkg::*;

  localparam int NC = 4;
  localparam int NW = 8;
  localparam int RW = 5;
  localparam int RB = RES_W;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          JOB_START = 1'b0;
  logic [RW-1:0] JOB_ROWS = '0;
  logic          JOB_KEEP_ADDR = 1'b0;
  logic          A_VALID = 1'b0;
  logic [7:0]    A_DATA = '0;
  logic          A_READY, PU_START, PU_RSTN, PU_PREVENT_ADR_CLR;
  logic [7:0]    PU_OP1;
  logic [1:0]    PU_ACC_NUM;
  logic          PU_DONE;
  logic [RB-1:0] PU_OUT;
  logic          RES_VALID;
  logic [RB-1:0] RES_DATA;
  logic          RES_READY;
  logic          BUSY, JOB_DONE, ERR;

  rowmat_scheduler dut (
    .CLK(CLK), .RSTN(RSTN), .JOB_START(JOB_START), .JOB_ROWS(JOB_ROWS),
    .JOB_KEEP_ADDR(JOB_KEEP_ADDR), .A_VALID(A_VALID), .A_DATA(A_DATA),
    .A_READY(A_READY), .PU_START(PU_START), .PU_OP1(PU_OP1),
    .PU_ACC_NUM(PU_ACC_NUM), .PU_RSTN(PU_RSTN),
    .PU_PREVENT_ADR_CLR(PU_PREVENT_ADR_CLR), .PU_DONE(PU_DONE),
    .PU_OUT(PU_OUT), .RES_VALID(RES_VALID), .RES_DATA(RES_DATA),
    .RES_READY(RES_READY), .BUSY(BUSY), .JOB_DONE(JOB_DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  logic signed [7:0] w [NC][NW];
  logic [RB-1:0] exp_q [$];

  // shared between stimulus (writer) and monitor/drivers (readers) or vice versa
  int  res_cnt = 0, done_cnt = 0, rst_lo_cnt = 0;
  int  res_base = 0, rdy_mode = 0, done_mode = 0;
  bit  job_keep = 1'b0, pu_mute = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // C row = A row x W, each lane truncated to 8 bits
  function automatic logic [RB-1:0] ref_row(input logic signed [7:0] a [NC]);
    logic [RB-1:0] r;
    int acc;
    r = '0;
    for (int j = 0; j < NW; j++) begin
      acc = 0;
      for (int i = 0; i < NC; i++) acc += int'(a[i]) * int'(w[i][j]);
      r[j*8 +: 8] = acc[7:0];
    end
    return r;
  endfunction

  // behavioural PU: collect NC elements after start, answer after a random delay,
  // hold DONE until soft reset
  int pu_st = 0, pu_cnt = 0, pu_wait = 0;
  logic signed [7:0] pu_col [NC];
  always @(posedge CLK) begin
    if (!PU_RSTN) begin
      pu_st   <= 0;
      pu_cnt  <= 0;
      PU_DONE <= 1'b0;
      PU_OUT  <= '0;
    end else begin
      case (pu_st)
        0: if (PU_START) begin pu_st <= 1; pu_cnt <= 0; end
        1: begin
          pu_col[pu_cnt] <= PU_OP1;
          pu_cnt <= pu_cnt + 1;
          if (pu_cnt == NC-1) begin pu_st <= 2; pu_wait <= $urandom_range(0, 4); end
        end
        2: begin
          if (pu_wait != 0) pu_wait <= pu_wait - 1;
          else if (!pu_mute) begin
            PU_DONE <= 1'b1;
            PU_OUT  <= ref_row(pu_col);
            pu_st   <= 3;
          end
        end
        default: ;
      endcase
    end
  end

  // downstream ready: 0 always, 1 random, 2 stall 5 cycles on a job's second row
  int stall = 0;
  initial begin
    RES_READY = 1'b0;
    forever begin
      @(posedge CLK); #1;
      case (rdy_mode)
        1: RES_READY = ($urandom_range(0, 2) != 0);
        2: if (RES_VALID && (res_cnt - res_base) == 1 && stall < 5) begin
             RES_READY = 1'b0;
             stall++;
           end else RES_READY = 1'b1;
        default: begin RES_READY = 1'b1; stall = 0; end
      endcase
    end
  end

  // monitor: start timing, feed order, ordering rule, results, done pulses
  logic [7:0]    acc_row [NC];
  int            acc_cnt = 0, feed_k = -1;
  bit            kick_pend = 0, stalled = 0, prev_rst_lo = 0;
  logic [RB-1:0] hold_data;
  always @(negedge CLK) begin
    if (!RSTN) begin
      acc_cnt = 0; feed_k = -1; kick_pend = 0; stalled = 0; prev_rst_lo = 0;
    end else begin
      if (PU_START || kick_pend) check("pu_start_timing", PU_START, kick_pend);
      if (PU_START) check("prevent_adr_clr", PU_PREVENT_ADR_CLR, job_keep);
      kick_pend = 0;
      if (feed_k >= 0) begin
        check("pu_op1_feed", PU_OP1, acc_row[feed_k]);
        feed_k++;
        if (feed_k == NC) feed_k = -1;
      end else if (BUSY) check("pu_op1_zero", PU_OP1, 8'h00);
      if (PU_START) feed_k = 0;
      if (A_VALID && A_READY) begin
        acc_row[acc_cnt] = A_DATA;
        acc_cnt++;
        if (acc_cnt == NC) begin acc_cnt = 0; kick_pend = 1; end
      end
      if (A_READY) check("a_ready_order", {RES_VALID, PU_START, !PU_RSTN}, 3'b000);
      if (RES_VALID) begin
        if (stalled) check("res_hold_stable", RES_DATA, hold_data);
        if (RES_READY) begin
          if (exp_q.size() == 0) bound_fail("unexpected_result");
          else check("res_data", RES_DATA, exp_q.pop_front());
          res_cnt++;
          stalled = 0;
        end else begin
          stalled = 1;
          hold_data = RES_DATA;
        end
      end
      if (JOB_DONE) begin
        done_cnt++;
        if (done_mode == 0) check("done_after_clr", prev_rst_lo, 1'b1);
        if (done_mode == 2) check("done_with_pu_rst", PU_RSTN, 1'b0);
      end
      if (!PU_RSTN) rst_lo_cnt++;
      prev_rst_lo = !PU_RSTN;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic start_job(input int rows, input bit keep);
    JOB_ROWS = RW'(rows);
    JOB_KEEP_ADDR = keep;
    JOB_START = 1'b1;
    tick();
    JOB_START = 1'b0;
  endtask

  task automatic send_elem(input logic [7:0] v, input int gap);
    int t;
    t = 0;
    A_VALID = 1'b1;
    A_DATA = v;
    do begin @(negedge CLK); t++; end while (!A_READY && t < 300);
    if (!A_READY) bound_fail("a_accept");
    tick();
    A_VALID = 1'b0;
    A_DATA = '0;
    repeat (gap) tick();
  endtask

  task automatic run_job(input int rows, input bit keep, input int gap_max,
                         input int rmode, input bit fixed);
    int eff, d0, t;
    logic signed [7:0] a [NC];
    eff = (rows > 16) ? 16 : rows;
    d0 = done_cnt;
    res_base = res_cnt;
    job_keep = keep;
    done_mode = 0;
    rdy_mode = rmode;
    start_job(rows, keep);
    for (int r = 0; r < eff; r++) begin
      for (int i = 0; i < NC; i++) a[i] = fixed ? 8'(i + 1) : 8'($urandom);
      exp_q.push_back(ref_row(a));
      for (int i = 0; i < NC; i++)
        send_elem(a[i], (gap_max > 0) ? $urandom_range(0, gap_max) : 0);
      if (r == 0 && eff > 1) start_job(0, !keep);
    end
    t = 0;
    while (done_cnt == d0 && t < 3000) begin tick(); t++; end
    if (done_cnt == d0) bound_fail("job_done_wait");
    repeat (3) tick();
    check("job_done_count", done_cnt - d0, 1);
    check("result_count", res_cnt - res_base, eff);
    check("scoreboard_empty", exp_q.size(), 0);
    check("busy_after_job", BUSY, 1'b0);
    rdy_mode = 0;
  endtask

  initial begin
    for (int i = 0; i < NC; i++)
      for (int j = 0; j < NW; j++) w[i][j] = 8'($urandom);

    // reset values
    repeat (3) tick();
    check("rst_outs", {A_READY, PU_START, RES_VALID, BUSY, JOB_DONE, ERR, PU_RSTN}, 7'b0);
    check("rst_pu_op1", PU_OP1, 8'h00);
    check("rst_res_data", RES_DATA, 64'h0);
    RSTN = 1'b1;
    tick();
    check("pu_acc_num", PU_ACC_NUM, 2'd3);
    check("pu_rstn_run", PU_RSTN, 1'b1);

    // single row {1,2,3,4}
    run_job(1, 1'b0, 0, 0, 1'b1);
    // three rows, second result stalled 5 cycles
    run_job(3, 1'b1, 0, 2, 1'b0);

    // zero-row job
    done_mode = 1;
    JOB_ROWS = '0;
    JOB_START = 1'b1;
    @(negedge CLK);
    check("zero_done_early", JOB_DONE, 1'b0);
    tick();
    JOB_START = 1'b0;
    @(negedge CLK);
    check("zero_done_pulse", JOB_DONE, 1'b1);
    check("zero_busy", BUSY, 1'b0);
    check("zero_no_start", PU_START, 1'b0);
    tick();
    @(negedge CLK);
    check("zero_done_single", {JOB_DONE, BUSY}, 2'b00);
    tick();

    // gapped input with random downstream ready
    run_job(2, 1'b0, 2, 1, 1'b0);

    // reset during FEED
    job_keep = 1'b1;
    done_mode = 0;
    res_base = res_cnt;
    start_job(2, 1'b1);
    for (int i = 0; i < NC; i++) send_elem(8'($urandom), 0);
    tick();
    #2 RSTN = 1'b0;
    #1;
    check("arst_outs", {A_READY, PU_START, RES_VALID, BUSY, JOB_DONE, ERR, PU_RSTN}, 7'b0);
    check("arst_pu_op1", PU_OP1, 8'h00);
    check("arst_res_data", RES_DATA, 64'h0);
    repeat (2) tick();
    RSTN = 1'b1;
    repeat (8) tick();
    check("arst_no_result", res_cnt - res_base, 0);
    run_job(2, 1'b1, 0, 1, 1'b0);

    // row count above MAX_ROWS clamps to 16
    run_job(20, 1'b0, 1, 1, 1'b0);

    for (int k = 0; k < 4; k++)
      run_job($urandom_range(1, 5), 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1, 1'b0);
    check("err_default", ERR, 1'b0);

`ifdef RMS_WATCHDOG_EN
    begin
      int d0, r0, l0, t;
      pu_mute = 1'b1;
      done_mode = 2;
      job_keep = 1'b0;
      d0 = done_cnt; r0 = res_cnt; l0 = rst_lo_cnt;
      start_job(1, 1'b0);
      for (int i = 0; i < NC; i++) send_elem(8'($urandom), 0);
      t = 0;
      while (done_cnt == d0 && t < 300) begin tick(); t++; end
      if (done_cnt == d0) bound_fail("wd_done_wait");
      repeat (3) tick();
      check("wd_err", ERR, 1'b1);
      check("wd_no_result", res_cnt - r0, 0);
      check("wd_busy", BUSY, 1'b0);
      check("wd_pu_rst_pulses", rst_lo_cnt - l0, 1);
      check("wd_done_count", done_cnt - d0, 1);
      pu_mute = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
